// File: rtl/hpm_pkg.sv
// -----------------------------------------------------------------------------
// hpm_pkg
// Shared definitions for the hardware performance-monitor controller:
//   - event selector codes and FSM state encoding
//   - CSR address map of the block
//   - bit positions inside the custom hpmctrl register
//   - per-cycle increment helper used by the top level
// -----------------------------------------------------------------------------
package hpm_pkg;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    COMMIT    = 3'd1,
    BRANCH    = 3'd2,
    MISPRED   = 3'd3,
    WFI_STALL = 3'd4
  } hpm_event_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FROZEN = 2'd1
  } hpm_state_e;

  localparam logic [11:0] CSR_MCOUNTINHIBIT   = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT_BASE  = 12'h323;
  localparam logic [11:0] CSR_MHPMCNT_LO_BASE = 12'hB03;
  localparam logic [11:0] CSR_MHPMCNT_HI_BASE = 12'hB83;
  localparam logic [11:0] CSR_HPMCTRL         = 12'h7C0;

  localparam int CTRL_FREEZE_BIT = 0;
  localparam int CTRL_IRQEN_BIT  = 1;
  localparam int CTRL_OVF_LSB    = 8;
  localparam int CTRL_STATE_LSB  = 16;
  localparam int INHIBIT_LSB     = 3;

  // Increment contributed by one cycle of events for a given selector.
  // Reserved codes 5..7 add nothing. The FROZEN/RUN gating is applied by
  // the caller, not here.
  function automatic logic [1:0] event_inc(input logic [2:0] sel,
                                           input logic [1:0] commit,
                                           input logic       branch,
                                           input logic       mispred);
    logic [1:0] inc;
    inc = 2'd0;
    case (sel)
      COMMIT:    inc = commit;
      BRANCH:    inc = {1'b0, branch};
      MISPRED:   inc = {1'b0, mispred};
      WFI_STALL: inc = 2'd1;
      default:   inc = 2'd0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/hpm_ctrl_if.sv
// -----------------------------------------------------------------------------
// hpm_ctrl_if
// Groups the event pulses and the CSR access bus of hpm_ctrl.
//   master : event sources / CSR requester (drives events, csr_re/we/addr/wdata)
//   slave  : hpm_ctrl (drives csr_rdata, csr_rvalid, csr_hit, ovf_irq)
// -----------------------------------------------------------------------------
interface hpm_ctrl_if;

  logic [1:0]  ev_commit;
  logic        ev_branch;
  logic        ev_mispredict;
  logic        ev_wfi;
  logic        csr_re;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic        csr_hit;
  logic        ovf_irq;

  modport master (
    output ev_commit, ev_branch, ev_mispredict, ev_wfi,
    output csr_re, csr_we, csr_addr, csr_wdata,
    input  csr_rdata, csr_rvalid, csr_hit, ovf_irq
  );

  modport slave (
    input  ev_commit, ev_branch, ev_mispredict, ev_wfi,
    input  csr_re, csr_we, csr_addr, csr_wdata,
    output csr_rdata, csr_rvalid, csr_hit, ovf_irq
  );

endinterface

// File: rtl/hpm_counter.sv
// -----------------------------------------------------------------------------
// hpm_counter
// One programmable event counter: CNT_W-bit count, 3-bit event selector and a
// sticky overflow flag.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   i_inc        : amount to add this cycle (0..3)
//   i_en         : increment enable (state/inhibit gating done by caller)
//   i_we_lo/hi   : CSR write to bits[31:0] / bits[63:32]
//   i_we_ev      : CSR write to the event selector
//   i_wdata      : CSR write data
//   i_ovf_clr    : clear the overflow flag
//   o_cnt        : live counter value
//   o_evsel      : current event selector
//   o_ovf        : sticky overflow flag
// -----------------------------------------------------------------------------
module hpm_counter
  import hpm_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_inc,
  input  logic             i_en,
  input  logic             i_we_lo,
  input  logic             i_we_hi,
  input  logic             i_we_ev,
  input  logic [31:0]      i_wdata,
  input  logic             i_ovf_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic [2:0]       o_evsel,
  output logic             o_ovf
);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_evsel;
  logic             r_ovf;
  logic [CNT_W:0]   w_sum;
  logic             w_inc_go;

  // Next count with carry-out; a CSR write to either half drops the increment.
  always_comb begin
    w_sum    = {1'b0, r_cnt} + {{(CNT_W-1){1'b0}}, i_inc};
    w_inc_go = i_en & ~i_we_lo & ~i_we_hi;
  end

  // Counter, selector and overflow flag state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_evsel <= 3'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (i_we_lo) begin
        r_cnt[31:0] <= i_wdata;
      end else if (i_we_hi) begin
        r_cnt[CNT_W-1:32] <= i_wdata[CNT_W-33:0];
      end else if (w_inc_go) begin
        r_cnt <= w_sum[CNT_W-1:0];
      end else begin
        r_cnt <= r_cnt;
      end

      // A wrap in the same edge as a clear keeps the flag set so no
      // overflow is ever silently lost.
      if (w_inc_go && w_sum[CNT_W]) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end

      if (i_we_ev) begin
        r_evsel <= i_wdata[2:0];
      end else begin
        r_evsel <= r_evsel;
      end
    end
  end

  assign o_cnt   = r_cnt;
  assign o_evsel = r_evsel;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/hpm_ctrl.sv
// -----------------------------------------------------------------------------
// hpm_ctrl
// Performance-monitor controller: N_CNT event counters, inhibit mask,
// freeze-on-WFI FSM, CSR decode/read mux and the atomic 64-bit read shadow.
// Ports:
//   clk   : core clock
//   rst_n : synchronous active-low reset
//   bus   : hpm_ctrl_if.slave (event pulses, CSR access, rdata/rvalid,
//           combinational csr_hit, registered ovf_irq)
// -----------------------------------------------------------------------------
module hpm_ctrl
  import hpm_pkg::*;
#(
  parameter int N_CNT = 4,
  parameter int CNT_W = 64
) (
  input logic         clk,
  input logic         rst_n,
  hpm_ctrl_if.slave   bus
);

  hpm_state_e       r_state;
  hpm_state_e       w_state_nxt;
  logic [N_CNT-1:0] r_inhibit;
  logic             r_freeze;
  logic             r_irq_en;
  logic             r_irq;
  logic [31:0]      r_rdata;
  logic             r_rvalid;
  logic [31:0]      r_shadow;
  logic             r_lo_rd_vld;
  logic [2:0]       r_lo_rd_idx;

  logic [CNT_W-1:0] w_cnt   [N_CNT];
  logic [2:0]       w_evsel [N_CNT];
  logic [1:0]       w_inc   [N_CNT];
  logic [N_CNT-1:0] w_ovf;
  logic [N_CNT-1:0] w_inc_en;
  logic [N_CNT-1:0] w_we_lo;
  logic [N_CNT-1:0] w_we_hi;
  logic [N_CNT-1:0] w_we_ev;
  logic [N_CNT-1:0] w_ovf_clr;

  logic             w_hit;
  logic             w_sel_inh;
  logic             w_sel_ctrl;
  logic             w_is_lo;
  logic [2:0]       w_idx;
  logic [31:0]      w_rd_val;
  logic [31:0]      w_shadow_nxt;
  logic [31:0]      w_ctrl_rd;
  logic             w_we_ctrl;
  logic             w_we_inh;

  // Read view of the hpmctrl register.
  always_comb begin
    w_ctrl_rd                                = 32'd0;
    w_ctrl_rd[CTRL_FREEZE_BIT]               = r_freeze;
    w_ctrl_rd[CTRL_IRQEN_BIT]                = r_irq_en;
    w_ctrl_rd[CTRL_OVF_LSB +: N_CNT]         = w_ovf;
    w_ctrl_rd[CTRL_STATE_LSB +: 2]           = r_state;
  end

  // Address decode, per-counter write strobes and read-data mux.
  always_comb begin
    w_hit        = 1'b0;
    w_sel_inh    = 1'b0;
    w_sel_ctrl   = 1'b0;
    w_is_lo      = 1'b0;
    w_idx        = 3'd0;
    w_rd_val     = 32'd0;
    w_shadow_nxt = r_shadow;
    w_we_lo      = '0;
    w_we_hi      = '0;
    w_we_ev      = '0;
    if (bus.csr_addr == CSR_MCOUNTINHIBIT) begin
      w_hit     = 1'b1;
      w_sel_inh = 1'b1;
      w_rd_val  = 32'(r_inhibit) << INHIBIT_LSB;
    end else if (bus.csr_addr == CSR_HPMCTRL) begin
      w_hit      = 1'b1;
      w_sel_ctrl = 1'b1;
      w_rd_val   = w_ctrl_rd;
    end else begin
      for (int k = 0; k < N_CNT; k++) begin
        if (bus.csr_addr == (CSR_MHPMEVENT_BASE + 12'(k))) begin
          w_hit      = 1'b1;
          w_we_ev[k] = bus.csr_we;
          w_rd_val   = {29'd0, w_evsel[k]};
        end else if (bus.csr_addr == (CSR_MHPMCNT_LO_BASE + 12'(k))) begin
          w_hit        = 1'b1;
          w_is_lo      = 1'b1;
          w_idx        = 3'(k);
          w_we_lo[k]   = bus.csr_we;
          w_rd_val     = w_cnt[k][31:0];
          w_shadow_nxt = 32'(w_cnt[k] >> 32);
        end else if (bus.csr_addr == (CSR_MHPMCNT_HI_BASE + 12'(k))) begin
          w_hit      = 1'b1;
          w_idx      = 3'(k);
          w_we_hi[k] = bus.csr_we;
          // Hi right after a lo read of the same counter returns the
          // snapshot so software sees a consistent 64-bit value.
          if (r_lo_rd_vld && (r_lo_rd_idx == 3'(k))) begin
            w_rd_val = r_shadow;
          end else begin
            w_rd_val = 32'(w_cnt[k] >> 32);
          end
        end else begin
          w_hit = w_hit;
        end
      end
    end
    w_we_ctrl = bus.csr_we & w_sel_ctrl;
    w_we_inh  = bus.csr_we & w_sel_inh;
  end

  // Per-counter increment amount and enable. WFI_STALL counts only while
  // frozen; every other event counts only while running.
  always_comb begin
    for (int k = 0; k < N_CNT; k++) begin
      w_inc[k]     = event_inc(w_evsel[k], bus.ev_commit, bus.ev_branch,
                               bus.ev_mispredict);
      w_inc_en[k]  = ~r_inhibit[k] &
                     ((w_evsel[k] == WFI_STALL) ? (r_state == FROZEN)
                                                : (r_state == RUN));
      w_ovf_clr[k] = w_we_ctrl & bus.csr_wdata[CTRL_OVF_LSB + k];
    end
  end

  for (genvar k = 0; k < N_CNT; k++) begin : g_cnt
    hpm_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_inc     (w_inc[k]),
      .i_en      (w_inc_en[k]),
      .i_we_lo   (w_we_lo[k]),
      .i_we_hi   (w_we_hi[k]),
      .i_we_ev   (w_we_ev[k]),
      .i_wdata   (bus.csr_wdata),
      .i_ovf_clr (w_ovf_clr[k]),
      .o_cnt     (w_cnt[k]),
      .o_evsel   (w_evsel[k]),
      .o_ovf     (w_ovf[k])
    );
  end

  // Freeze FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (bus.ev_wfi && r_freeze) begin
          w_state_nxt = FROZEN;
        end else begin
          w_state_nxt = RUN;
        end
      end
      FROZEN: begin
        if (w_we_ctrl && !bus.csr_wdata[CTRL_FREEZE_BIT]) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = FROZEN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Freeze FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control registers, read pipeline, shadow and interrupt output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inhibit   <= '0;
      r_freeze    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
      r_rdata     <= 32'd0;
      r_rvalid    <= 1'b0;
      r_shadow    <= 32'd0;
      r_lo_rd_vld <= 1'b0;
      r_lo_rd_idx <= 3'd0;
    end else begin
      if (w_we_inh) begin
        r_inhibit <= bus.csr_wdata[INHIBIT_LSB +: N_CNT];
      end else begin
        r_inhibit <= r_inhibit;
      end

      if (w_we_ctrl) begin
        r_freeze <= bus.csr_wdata[CTRL_FREEZE_BIT];
        r_irq_en <= bus.csr_wdata[CTRL_IRQEN_BIT];
      end else begin
        r_freeze <= r_freeze;
        r_irq_en <= r_irq_en;
      end

      r_irq    <= r_irq_en & (|w_ovf);
      r_rvalid <= bus.csr_re & w_hit;

      if (bus.csr_re && w_hit) begin
        r_rdata <= w_rd_val;
      end else begin
        r_rdata <= r_rdata;
      end

      if (bus.csr_re && w_is_lo) begin
        r_shadow <= w_shadow_nxt;
      end else begin
        r_shadow <= r_shadow;
      end

      // Remember whether the most recent access to this block was a lo read.
      if ((bus.csr_re || bus.csr_we) && w_hit) begin
        r_lo_rd_vld <= bus.csr_re & w_is_lo;
        r_lo_rd_idx <= w_idx;
      end else begin
        r_lo_rd_vld <= r_lo_rd_vld;
        r_lo_rd_idx <= r_lo_rd_idx;
      end
    end
  end

  assign bus.csr_rdata  = r_rdata;
  assign bus.csr_rvalid = r_rvalid;
  assign bus.csr_hit    = w_hit;
  assign bus.ovf_irq    = r_irq;

endmodule

// File: doc/hpm_ctrl.md
Name: hpm_ctrl

Overview:
Hardware performance-monitor controller for the dual-issue rv32im_vector core.
- Owns N_CNT programmable 64-bit event counters, their event selectors, an inhibit mask and a freeze-on-WFI control.
- Sits beside the CSR register file in the execute-stage LSU/CSR unit.
- Takes one-cycle event pulses from decode, the branch predictor and the ROB. Answers CSR reads/writes in the mhpmcounter/mhpmevent address space.

Parameters:
- N_CNT, 4, number of programmable counters (mhpmcounter3..3+N_CNT-1), legal 1..8
- CNT_W, 64, counter width in bits

Ports:
- clk, input, 1, core clock
- rst_n, input, 1, synchronous active-low reset
- ev_commit, input, 2, instructions retired this cycle by the ROB (0..2)
- ev_branch, input, 1, branch resolved this cycle
- ev_mispredict, input, 1, branch mispredicted this cycle
- ev_wfi, input, 1, WFI decoded in either decoder slot
- csr_re, input, 1, CSR read strobe
- csr_we, input, 1, CSR write strobe
- csr_addr, input, 12, CSR address
- csr_wdata, input, 32, CSR write data
- csr_rdata, output, 32, read data, registered
- csr_rvalid, output, 1, read data valid, one cycle after csr_re
- csr_hit, output, 1, combinational: csr_addr decodes to a register owned by this block
- ovf_irq, output, 1, OR of enabled sticky overflow flags

Behaviour:
- Reset (rst_n low at a clk edge) clears:
  - all counters, event selectors, inhibit mask, ctrl, overflow flags and hi shadow;
  - csr_rdata=0, csr_rvalid=0, ovf_irq=0, state=RUN.
  - Reset in the middle of a read drops the pending rvalid.
- Address map:
  - 0x320 mcountinhibit: bit 3+k inhibits counter k; other bits read 0.
  - 0x323+k mhpmevent(k): bits[2:0] select the event.
  - 0xB03+k: counter k bits[31:0]. 0xB83+k: counter k bits[63:32].
  - 0x7C0 hpmctrl (custom):
    - bit0 freeze_on_wfi;
    - bit1 irq_en;
    - bits[15:8] overflow flags, write-1-to-clear;
    - bits[17:16] state, read-only.
  - Any other address: csr_hit=0, block ignores the access.
- Event codes and per-cycle increment:
  - 0 none, adds 0;
  - 1 commit, adds ev_commit (0, 1 or 2);
  - 2 branch, adds 1;
  - 3 mispredict, adds 1;
  - 4 wfi-stall, adds 1 each cycle in FROZEN;
  - 5-7 reserved, behave as 0.
- Counter k increments only when state=RUN and its inhibit bit=0. Event 4 is the exception: it counts in FROZEN and ignores the freeze.
- Wrap-around: an increment crossing 2^64-1 wraps modulo 2^64 and sets overflow flag k in the same edge. Flag stays set until software clears it.
- ovf_irq = irq_en & |flags, registered, so it rises one cycle after the flag.
- State machine:
  - RUN -> FROZEN when ev_wfi=1 and freeze_on_wfi=1.
  - FROZEN -> RUN on any CSR write to hpmctrl with bit0=0.
  - ev_wfi while freeze_on_wfi=0 has no effect.
- CSR write vs increment on the same counter and edge: the write wins and the increment is lost. A lo write leaves hi unchanged; a hi write leaves lo unchanged.
- Atomic 64-bit read:
  - A read of lo returns lo and copies hi into the shadow in the same edge.
  - A read of hi returns the shadow if the previous CSR access was a lo read of the same k, otherwise the live hi.
- csr_re and csr_we together on the same address: the read returns the pre-write value.

Decomposition:
- Package hpm_pkg:
  - hpm_event_e enum (NONE, COMMIT, BRANCH, MISPRED, WFI_STALL);
  - hpm_state_e (RUN, FROZEN);
  - CSR address localparams;
  - CTRL bit positions.
- Sub-module hpm_counter, instantiated N_CNT times. It holds one 64-bit counter, its event register and its overflow flag, with inputs: inc amount (2 bits), enable, write-lo, write-hi, wdata.
- Top level: address decode, read mux, shadow, FSM.

Test Plan:
1. Reset, sel0=COMMIT, drive ev_commit=2 for 10 cycles, then 1 for 5 -> read 0xB03 gives 25, 0xB83 gives 0, csr_rvalid exactly one cycle after csr_re.
2. Write lo=0xFFFFFFFF and hi=0xFFFFFFFF on counter 1 (sel=BRANCH), irq_en=1, pulse ev_branch once -> counter 0, flag bit9 set, ovf_irq high the next cycle; write hpmctrl bits[15:8]=0x02 -> ovf_irq low.
3. freeze_on_wfi=1, sel0=COMMIT, sel1=WFI_STALL, pulse ev_wfi, then 20 cycles of ev_commit=1 -> counter0 unchanged, counter1=20, state reads 1; write hpmctrl bit0=0 -> RUN, counter0 resumes.
4. Counter2 (MISPRED) at lo=0xFFFFFFFF: read lo (shadow=0), pulse mispredict (hi becomes 1), read hi -> returns 0; repeat the hi read without the preceding lo read -> returns 1.
5. Set mcountinhibit bit4 and write counter1 lo=5 in the same cycle as ev_branch -> counter1 reads 5; clear inhibit, pulse ev_branch -> reads 6.
6. Access 0x7C5, then assert rst_n=0 for one edge during a pending read -> csr_hit=0 for the access and no rvalid; after reset all registers read 0.
